// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch feeding a DEPTH-entry instruction
// queue. Memory responses return in request order; queue slots are reserved
// when a request is issued, so the queue can never overflow. A redirect
// flushes the queue, reloads the fetch PC and squashes every response still
// in flight. Responses issued before a reset are also squashed.
// Optional feature: define FETCH_ALIGN_CHECK_EN to raise a sticky
// misalign_fault and halt fetching on a redirect to a non-word-aligned target.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(32'h00400020),
  parameter int                DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_rsp_valid,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       ins_valid,
  input  logic                       ins_ready,
  output logic [DATA_W-1:0]          ins_data,
  output logic [ADDR_W-1:0]          ins_pc,
  output logic [$clog2(DEPTH+1)-1:0] ins_count,
  output logic                       misalign_fault
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  squash_cnt;
  logic [CNT_W-1:0]  mem_inflight;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  out_base;
  logic [CNT_W-1:0]  sq_base;
  logic [CNT_W-1:0]  out_next;
  logic [CNT_W-1:0]  squash_next;
  logic [CNT_W:0]    occupancy;
  logic              reload;
  logic              halted;
  logic              rsp_squash;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Instruction words are always word aligned; the low target bits are dropped.
  assign target_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // A misaligned redirect latches the fault; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (redirect_valid && misaligned) begin
      halted <= 1'b1;
    end
  end
`else
  logic [1:0] unused_pc_bits;
  assign unused_pc_bits = redirect_pc[1:0];
  assign halted         = 1'b0;
`endif

  assign misalign_fault = halted;

  // In the first cycle after reset the counters take over the memory-side
  // in-flight count, so requests issued before reset are squashed on return.
  always_comb begin
    out_base    = reload ? mem_inflight : outstanding;
    sq_base     = reload ? mem_inflight : squash_cnt;
    occupancy   = {1'b0, count_q} + {1'b0, out_base};
    imem_req    = !reset && !redirect_valid && !halted &&
                  (occupancy < (CNT_W+1)'(DEPTH));
    rsp_squash  = imem_rsp_valid && (sq_base != '0);
    push        = imem_rsp_valid && !rsp_squash && !redirect_valid && !reset;
    pop         = ins_valid && ins_ready && !redirect_valid;
    out_next    = out_base + CNT_W'(imem_req) - CNT_W'(imem_rsp_valid);
    squash_next = sq_base;
    if (redirect_valid) begin
      squash_next = out_next;
    end else if (rsp_squash) begin
      squash_next = sq_base - CNT_W'(1);
    end
  end

  assign imem_addr = fetch_pc;
  assign ins_count = count_q;
  assign ins_valid = (count_q != '0);
  assign ins_data  = data_mem[rd_ptr];
  assign ins_pc    = pc_mem[rd_ptr];

  // Memory-side in-flight count; pending reads survive a reset of this unit,
  // so this counter deliberately keeps counting through reset.
  always_ff @(posedge clk) begin
    mem_inflight <= mem_inflight + CNT_W'(imem_req) - CNT_W'(imem_rsp_valid);
  end

  // Queue storage: each accepted response is stored with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

  // Fetch PC, response PC tracking, queue pointers and request accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= PC_START;
      rsp_pc      <= PC_START;
      outstanding <= '0;
      squash_cnt  <= '0;
      count_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      reload      <= 1'b1;
    end else begin
      reload      <= 1'b0;
      outstanding <= out_next;
      squash_cnt  <= squash_next;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        count_q  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + ADDR_W'(4);
        end
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          rsp_pc <= rsp_pc + ADDR_W'(4);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. An in-order memory with
// random latency serves requests; a transaction-level model tags each request
// with a redirect/reset epoch, keeps the expected instruction queue as a
// queue of {pc, data}, and predicts the request and output behaviour.
module tb_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_START = 32'h00400020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic [2:0]  ins_count;
  logic        misalign_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_START(PC_START), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc),
    .ins_count(ins_count), .misalign_fault(misalign_fault)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        pend[$];
  ent_t        q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          rsp_pct = 100;
  int          lat_max = 0;
  int          cyc = 0;
  int          epoch = 0;
  logic [31:0] m_pc = PC_START;
  bit          m_halt = 1'b0;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model to what the next rising edge should produce.
  task automatic applyStimulus(input bit do_reset, input bit do_redir,
                               input logic [31:0] tgt, input bit ready);
    bit   rsp_now;
    bit   exp_req;
    bit   pop_now;
    req_t r;
    ent_t e;
    @(negedge clk);
    reset          = do_reset;
    redirect_valid = do_redir;
    redirect_pc    = tgt;
    ins_ready      = ready;
    rsp_now = (pend.size() > 0) && (pend[0].due <= cyc) &&
              ($urandom_range(0, 99) < rsp_pct);
    imem_rsp_valid = rsp_now;
    imem_rdata     = rsp_now ? dataOf(pend[0].addr) : $urandom;
    if (do_reset) begin
      q.delete();
      epoch++;
      m_pc   = PC_START;
      m_halt = 1'b0;
    end
    #1;
    exp_req = !do_reset && !do_redir && !m_halt && ((q.size() + pend.size()) < DEPTH);
    checkOutput("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) checkOutput("imem_addr", 64'(imem_addr), 64'(m_pc));
    checkOutput("ins_count", 64'(ins_count), 64'(q.size()));
    checkOutput("ins_valid", 64'(ins_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      checkOutput("ins_pc", 64'(ins_pc), 64'(q[0].pc));
      checkOutput("ins_data", 64'(ins_data), 64'(q[0].data));
    end
    checkOutput("misalign_fault", 64'(misalign_fault), 64'(m_halt));
    pop_now = !do_reset && !do_redir && ready && (q.size() != 0);
    if (pop_now) void'(q.pop_front());
    if (rsp_now) begin
      r = pend.pop_front();
      if (!do_reset && !do_redir && r.epoch == epoch) begin
        e.pc   = r.addr;
        e.data = dataOf(r.addr);
        q.push_back(e);
      end
    end
    if (do_redir && !do_reset) begin
      q.delete();
      epoch++;
      m_pc = {tgt[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) m_halt = 1'b1;
`endif
    end
    if (exp_req) begin
      r.addr  = m_pc;
      r.epoch = epoch;
      r.due   = cyc + 1 + $urandom_range(0, lat_max);
      pend.push_back(r);
      m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    bit          rst_b;
    bit          red_b;
    logic [31:0] tgt;

    repeat (3) applyStimulus(1, 0, 32'h0, 0);

    // Streaming with single-cycle memory and decode always ready.
    rsp_pct = 100; lat_max = 0;
    repeat (12) applyStimulus(0, 0, 32'h0, 1);

    // Decode stalls: queue fills to DEPTH, then one pop frees one slot.
    repeat (10) applyStimulus(0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 1);
    repeat (6) applyStimulus(0, 0, 32'h0, 0);

    // Drain with memory silent so requests pile up, then redirect.
    rsp_pct = 0;
    repeat (4) applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 1, 32'h00400100, 1);
    rsp_pct = 100; lat_max = 2;
    repeat (15) applyStimulus(0, 0, 32'h0, 1);

    // Address wrap past all-ones.
    applyStimulus(0, 1, 32'hFFFFFFF4, 1);
    repeat (12) applyStimulus(0, 0, 32'h0, 1);

    // Misaligned redirect target.
    applyStimulus(0, 1, 32'h00400102, 1);
    repeat (10) applyStimulus(0, 0, 32'h0, 1);
    repeat (2) applyStimulus(1, 0, 32'h0, 1);

    // Reset pulsed with two requests still outstanding.
    rsp_pct = 0; lat_max = 0;
    repeat (2) applyStimulus(0, 0, 32'h0, 1);
    repeat (2) applyStimulus(1, 0, 32'h0, 1);
    rsp_pct = 100;
    repeat (10) applyStimulus(0, 0, 32'h0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 100) == 0) begin
        rsp_pct = $urandom_range(40, 100);
        lat_max = $urandom_range(0, 3);
      end
      rst_b = ($urandom_range(0, 199) == 0);
      red_b = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      if ($urandom_range(0, 4) != 0) tgt[1:0] = 2'b00;
      applyStimulus(rst_b, red_b, tgt, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: PC and instruction-memory address width in bits.
REQ-002 Parameter DATA_W, default 32: instruction word width in bits.
REQ-003 Parameter PC_START, default 32'h00400020: PC value loaded at reset.
REQ-004 Parameter DEPTH, default 4, legal range 2..16: instruction queue entries and maximum outstanding memory requests.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 redirect_valid  in  1  branch/jump redirect request from a later stage.
REQ-008 redirect_pc  in  ADDR_W  redirect target address.
REQ-009 imem_req  out  1  instruction-memory read request, one word per asserted cycle.
REQ-010 imem_addr  out  ADDR_W  request address; equals the current fetch PC.
REQ-011 imem_rsp_valid  in  1  read data returned; responses arrive in request order, at least 1 cycle after their request.
REQ-012 imem_rdata  in  DATA_W  returned instruction word.
REQ-013 ins_valid  out  1  queue head holds a valid instruction.
REQ-014 ins_ready  in  1  decode accepts the head entry.
REQ-015 ins_data  out  DATA_W  head instruction.
REQ-016 ins_pc  out  ADDR_W  PC of the head instruction.
REQ-017 ins_count  out  $clog2(DEPTH+1)  number of queue entries occupied.
REQ-018 misalign_fault  out  1  sticky misaligned-redirect flag.

Function
REQ-019 imem_req SHALL be asserted when (ins_count + outstanding) < DEPTH, redirect_valid is 0, and the unit is not halted.
REQ-020 On each cycle with imem_req=1, fetch PC SHALL advance by 4, modulo 2^ADDR_W; the PC wraps from all-ones-minus-3 to 0.
REQ-021 The outstanding counter SHALL increment on each request and decrement on each imem_rsp_valid; both in one cycle leave it unchanged.
REQ-022 A non-squashed response SHALL be pushed into the queue with its request PC and become visible on ins_* the following cycle.
REQ-023 Pop SHALL occur when ins_valid and ins_ready are both 1; ins_data and ins_pc SHALL be stable while ins_valid=1 and ins_ready=0.
REQ-024 A push and a pop in the same cycle SHALL be legal at any occupancy; overflow cannot occur because slots are reserved at request time (REQ-019).
REQ-025 When redirect_valid=1: the queue SHALL be flushed, fetch PC SHALL be loaded with redirect_pc, imem_req SHALL be 0 that cycle, and all outstanding responses SHALL be squashed (discarded on arrival).
REQ-026 A pop handshake coinciding with a redirect SHALL be discarded with the flush.
REQ-027 The first request after a redirect SHALL occur on the next cycle, with imem_addr = redirect_pc.
REQ-028 Back-to-back redirects: the last one wins; the squash count SHALL accumulate to cover all in-flight requests.
REQ-029 ins_count SHALL equal the number of valid queue entries at every cycle.

Reset
REQ-030 While reset=1: fetch PC = PC_START, queue empty, outstanding = 0, squash count = 0, imem_req = 0, ins_valid = 0, ins_count = 0, misalign_fault = 0.
REQ-031 On the first clock edge after reset deasserts, imem_req SHALL be 1 with imem_addr = PC_START.
REQ-032 Reset asserted mid-operation SHALL take effect immediately; responses arriving after reset is released SHALL be ignored only if they were issued before reset (squash count reloads to the outstanding count).

Configuration
REQ-033 Macro FETCH_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0] != 0 SHALL set misalign_fault, flush as in REQ-025, and halt requests until reset.
REQ-034 Macro FETCH_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 0, and misalign_fault SHALL be tied to 0.

Verification
REQ-035 Reset release, memory with 1-cycle latency, ins_ready=1 -> imem_addr sequence 0x00400020, 0x00400024, 0x00400028...; ins_pc follows 2 cycles behind.
REQ-036 DEPTH=4, ins_ready=0 -> exactly 4 requests are issued, ins_count reaches 4, and imem_req stays 0; one pop -> exactly one new request.
REQ-037 Redirect to 0x00400100 with 3 requests outstanding -> the queue empties and the 3 late responses are dropped; the next ins_pc is 0x00400100.
REQ-038 ADDR_W=32, PC = 0xFFFFFFFC -> the next request address is 0x00000000.
REQ-039 With FETCH_ALIGN_CHECK_EN, redirect_pc = 0x00400102 -> misalign_fault=1 and imem_req stays 0 until reset; without the macro, the fetch proceeds from 0x00400100.
REQ-040 Reset pulsed with 2 responses outstanding -> after release, neither stale response enters the queue; the first ins_pc is PC_START.
